// File: rtl/pam4_tx_upsampler.sv
// PAM4 symbol source (PRBS or external stream), Gray-mapped to 1s17 levels
// and zero-stuffed to SPS samples per symbol for the pulse-shaping FIR.
module pam4_tx_upsampler #(
    parameter int          SPS       = 4,
    parameter logic [14:0] LFSR_SEED = 15'h0001
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ce,
    input  logic               src_sel,
    input  logic [1:0]         sym_data,
    input  logic               sym_valid,
    output logic               sym_ready,
    output logic signed [17:0] x_out,
    output logic               x_valid,
    output logic               sym_strobe,
    output logic               underrun
);

    localparam int          PH_W     = (SPS > 2) ? $clog2(SPS) : 1;
    localparam logic [14:0] SEED_EFF = (LFSR_SEED == 15'h0000) ? 15'h0001 : LFSR_SEED;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(SPS - 1);

    logic [PH_W-1:0]    ph_q, ph_d;
    logic [14:0]        lfsr_q, lfsr_d;
    logic signed [17:0] x_q, x_d;
    logic               valid_q, valid_d;
    logic               strobe_q, strobe_d;
    logic               urun_q, urun_d;

    logic        fb1, fb2;
    logic [14:0] lfsr_mid, lfsr_two;
    logic [1:0]  sym_bits;
    logic        have_sym;
    logic        slot;
    logic signed [17:0] level;

    // Two LFSR shifts per symbol: first feedback bit is b1, second is b0.
    assign fb1      = lfsr_q[14] ^ lfsr_q[13];
    assign lfsr_mid = {lfsr_q[13:0], fb1};
    assign fb2      = lfsr_mid[14] ^ lfsr_mid[13];
    assign lfsr_two = {lfsr_mid[13:0], fb2};

    assign slot      = ce & (ph_q == '0);
    assign sym_ready = slot & src_sel & ~reset;
    assign sym_bits  = src_sel ? sym_data : {fb1, fb2};
    assign have_sym  = ~src_sel | sym_valid;

    always_comb begin
        level = '0;
        case (sym_bits)
            2'b00:   level = -18'sd98304;
            2'b01:   level = -18'sd32768;
            2'b11:   level =  18'sd32768;
            default: level =  18'sd98304;
        endcase
    end

    always_comb begin
        ph_d     = ph_q;
        lfsr_d   = lfsr_q;
        x_d      = x_q;
        valid_d  = 1'b0;
        strobe_d = strobe_q;
        urun_d   = urun_q;
        if (ce) begin
            valid_d  = 1'b1;
            ph_d     = (ph_q == PH_LAST) ? '0 : ph_q + 1'b1;
            x_d      = '0;
            strobe_d = 1'b0;
            // The slot is spent even when the external symbol is missing.
            if (slot) begin
                lfsr_d = lfsr_two;
                if (have_sym) begin
                    x_d      = level;
                    strobe_d = 1'b1;
                end else begin
                    urun_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ph_q     <= '0;
            lfsr_q   <= SEED_EFF;
            x_q      <= '0;
            valid_q  <= 1'b0;
            strobe_q <= 1'b0;
            urun_q   <= 1'b0;
        end else begin
            ph_q     <= ph_d;
            lfsr_q   <= lfsr_d;
            x_q      <= x_d;
            valid_q  <= valid_d;
            strobe_q <= strobe_d;
            urun_q   <= urun_d;
        end
    end

    assign x_out      = x_q;
    assign x_valid    = valid_q;
    assign sym_strobe = strobe_q;
    assign underrun   = urun_q;

endmodule

// File: tb/tb_pam4_tx_upsampler.sv
// Bench for pam4_tx_upsampler: two instances (seed 6000 and seed 0) driven in
// lockstep, checked every cycle against a bit-stream PRBS / level model.
module tb_pam4_tx_upsampler;

    localparam int SPS    = 4;
    localparam int NBITS  = 2048;

    logic clk = 1'b0;
    logic reset, ce, src_sel, sym_valid;
    logic [1:0] sym_data;

    logic               a_ready, a_valid, a_strobe, a_urun;
    logic signed [17:0] a_x;
    logic               z_ready, z_valid, z_strobe, z_urun;
    logic signed [17:0] z_x;

    always #5 clk = ~clk;

    pam4_tx_upsampler #(.SPS(SPS), .LFSR_SEED(15'h6000)) dut (
        .clk(clk), .reset(reset), .ce(ce), .src_sel(src_sel),
        .sym_data(sym_data), .sym_valid(sym_valid), .sym_ready(a_ready),
        .x_out(a_x), .x_valid(a_valid), .sym_strobe(a_strobe), .underrun(a_urun)
    );

    pam4_tx_upsampler #(.SPS(SPS), .LFSR_SEED(15'h0000)) dut_z (
        .clk(clk), .reset(reset), .ce(ce), .src_sel(src_sel),
        .sym_data(sym_data), .sym_valid(sym_valid), .sym_ready(z_ready),
        .x_out(z_x), .x_valid(z_valid), .sym_strobe(z_strobe), .underrun(z_urun)
    );

    int checks = 0;
    int errors = 0;

    // PRBS as a bit stream: y[n] = y[n-15] ^ y[n-14], first 15 bits = seed MSB first.
    bit ya [0:NBITS-1];
    bit yz [0:NBITS-1];

    int mph, pidx, step_no, ready_cnt, z_nonconst;
    int exp_xa, exp_xz;
    bit exp_valid, exp_sa, exp_sz, exp_urun, exp_ready;

    function automatic int lvl(bit b1, bit b0);
        int k;
        k = b1 ? (b0 ? 2 : 3) : (b0 ? 1 : 0);
        return (2 * k - 3) * 32768;
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (step %0d)", name, act, expv, step_no);
        end
    endtask

    task automatic step(input logic r, input logic c, input logic s,
                        input logic [1:0] d, input logic v);
        int la, lz;
        reset = r; ce = c; src_sel = s; sym_data = d; sym_valid = v;
        #1;
        exp_ready = !r && c && (mph == 0) && s;
        chk("sym_ready_a", int'(a_ready), int'(exp_ready));
        chk("sym_ready_z", int'(z_ready), int'(exp_ready));
        if (a_ready) ready_cnt++;
        @(posedge clk);
        if (r) begin
            mph = 0; pidx = 0; exp_xa = 0; exp_xz = 0;
            exp_valid = 0; exp_sa = 0; exp_sz = 0; exp_urun = 0;
        end else if (c) begin
            exp_valid = 1;
            exp_xa = 0; exp_xz = 0; exp_sa = 0; exp_sz = 0;
            if (mph == 0) begin
                la = lvl(ya[pidx+15], ya[pidx+16]);
                lz = lvl(yz[pidx+15], yz[pidx+16]);
                pidx += 2;
                if (!s) begin
                    exp_xa = la; exp_xz = lz; exp_sa = 1; exp_sz = 1;
                end else if (v) begin
                    exp_xa = lvl(d[1], d[0]); exp_xz = exp_xa; exp_sa = 1; exp_sz = 1;
                end else begin
                    exp_urun = 1;
                end
            end
            mph = (mph + 1) % SPS;
        end else begin
            exp_valid = 0;
        end
        #1;
        step_no++;
        chk("x_out_a", int'(a_x), exp_xa);
        chk("x_out_z", int'(z_x), exp_xz);
        chk("x_valid_a", int'(a_valid), int'(exp_valid));
        chk("x_valid_z", int'(z_valid), int'(exp_valid));
        chk("strobe_a", int'(a_strobe), int'(exp_sa));
        chk("strobe_z", int'(z_strobe), int'(exp_sz));
        chk("underrun_a", int'(a_urun), int'(exp_urun));
        chk("underrun_z", int'(z_urun), int'(exp_urun));
        if (z_strobe && int'(z_x) != -98304) z_nonconst++;
        $display("step %0d rst=%0b ce=%0b src=%0b d=%0d v=%0b | a_x=%0d s=%0b z_x=%0d s=%0b urun=%0b",
                 step_no, r, c, s, d, v, a_x, a_strobe, z_x, z_strobe, a_urun);
    endtask

    logic [1:0] ext_syms [4];
    int         ext_lvls [4];

    initial begin
        logic [14:0] sa, sz;
        sa = 15'h6000;
        sz = 15'h0001;
        for (int i = 0; i < 15; i++) begin
            ya[i] = sa[14-i];
            yz[i] = sz[14-i];
        end
        for (int n = 15; n < NBITS; n++) begin
            ya[n] = ya[n-15] ^ ya[n-14];
            yz[n] = yz[n-15] ^ yz[n-14];
        end
        ext_syms[0] = 2'b00; ext_syms[1] = 2'b01; ext_syms[2] = 2'b11; ext_syms[3] = 2'b10;
        ext_lvls[0] = -98304; ext_lvls[1] = -32768; ext_lvls[2] = 32768; ext_lvls[3] = 98304;
        mph = 0; pidx = 0; step_no = 0; ready_cnt = 0; z_nonconst = 0;
        exp_xa = 0; exp_xz = 0; exp_valid = 0; exp_sa = 0; exp_sz = 0; exp_urun = 0;

        // Reset state
        step(1, 1, 0, 2'b00, 0);
        step(1, 1, 0, 2'b00, 0);
        chk("reset_x", int'(a_x), 0);
        chk("reset_valid", int'(a_valid), 0);

        // PRBS from seed 6000: 01, then zeros, then 00
        step(0, 1, 0, 2'b00, 0);
        chk("prbs_first", int'(a_x), -32768);
        chk("prbs_first_strobe", int'(a_strobe), 1);
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 0, 2'b00, 0);
            chk("prbs_stuff", int'(a_x), 0);
        end
        step(0, 1, 0, 2'b00, 0);
        chk("prbs_fifth", int'(a_x), -98304);
        for (int k = 0; k < 35; k++) step(0, 1, 0, 2'b00, 0);

        // External mapping
        step(1, 1, 0, 2'b00, 0);
        ready_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            step(0, 1, 1, ext_syms[k/4], 1);
            if (k % 4 == 0) chk("ext_level", int'(a_x), ext_lvls[k/4]);
        end
        chk("ext_ready_pulses", ready_cnt, 4);

        // Underrun: one missing slot, then resume
        for (int k = 0; k < 4; k++) step(0, 1, 1, 2'b11, 1);
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 1, 2'b11, 0);
            if (k == 0) begin
                chk("urun_slot_x", int'(a_x), 0);
                chk("urun_slot_strobe", int'(a_strobe), 0);
                chk("urun_set", int'(a_urun), 1);
            end
        end
        step(0, 1, 1, 2'b10, 1);
        chk("urun_resume", int'(a_x), 98304);
        chk("urun_sticky", int'(a_urun), 1);
        for (int k = 0; k < 7; k++) step(0, 1, 1, 2'b10, 1);
        step(1, 1, 1, 2'b10, 1);
        chk("urun_cleared", int'(a_urun), 0);

        // ce gating: symbol period becomes 8 clocks, output holds while ce=0
        for (int k = 0; k < 32; k++) begin
            step(0, (k % 2 == 0), 0, 2'b00, 0);
            if (k == 0) chk("gate_first", int'(a_x), -32768);
            if (k == 1) begin
                chk("gate_hold", int'(a_x), -32768);
                chk("gate_valid_low", int'(a_valid), 0);
            end
            if (k == 8) chk("gate_second", int'(a_x), -98304);
        end

        // Reset mid-symbol at ph=2
        step(1, 1, 0, 2'b00, 0);
        step(0, 1, 0, 2'b00, 0);
        step(0, 1, 0, 2'b00, 0);
        step(1, 1, 0, 2'b00, 0);
        chk("midrst_x", int'(a_x), 0);
        chk("midrst_strobe", int'(a_strobe), 0);
        chk("midrst_valid", int'(a_valid), 0);
        step(0, 1, 0, 2'b00, 0);
        chk("midrst_restart", int'(a_x), -32768);
        for (int k = 0; k < 60; k++) step(0, 1, 0, 2'b00, 0);

        // Zero seed must behave as seed 1 (model) and not be a constant stream
        checks++;
        if (z_nonconst == 0) begin
            errors++;
            $display("FAIL zero_seed_nonconst: got %0d non-minimum strobes expected >0", z_nonconst);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
